// File: rtl/shift_instr_encoder.sv
// Encodes MIPS R-type shift requests into instruction words and streams them to memory.
// Optional NOP_PAD_EN: follows every word with a 0x00000000 pad word at the next address.
module shift_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_shamt,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err_illegal,
  output logic              wrapped
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef NOP_PAD_EN
  localparam logic [1:0] ST_PAD   = 2'd2;
`endif

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

  // Request FIFO holding fully encoded instruction words
  logic [31:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_wrapped;
  logic              r_err;
  logic              r_ready;
  logic              r_busy;

  logic [1:0]        w_state_nx;
  logic              w_we_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [31:0]       w_wdata_nx;
  logic              w_wrapped_nx;
  logic              w_pop;
  logic              w_inc;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count_nx;
  logic [31:0]       w_word;

  function automatic logic [31:0] encode_shift(
    input logic [2:0] op,
    input logic [4:0] rd,
    input logic [4:0] rt,
    input logic [4:0] rs,
    input logic [4:0] shamt
  );
    logic [5:0] funct;
    logic       is_var;
    funct  = 6'h00;
    is_var = 1'b0;
    case (op)
      3'd0:    funct = 6'h00;
      3'd1:    funct = 6'h02;
      3'd2:    funct = 6'h03;
      3'd3:    begin funct = 6'h04; is_var = 1'b1; end
      3'd4:    begin funct = 6'h06; is_var = 1'b1; end
      3'd5:    begin funct = 6'h07; is_var = 1'b1; end
      default: funct = 6'h00;
    endcase
    encode_shift = {6'b000000, (is_var ? rs : 5'd0), rt, rd,
                    (is_var ? 5'd0 : shamt), funct};
  endfunction

  assign w_word    = encode_shift(req_op, req_rd, req_rt, req_rs, req_shamt);
  assign w_accept  = req_valid & r_ready;
  assign w_illegal = req_op[2] & req_op[1];
  assign w_push    = w_accept & ~w_illegal;
  assign w_empty   = (r_count == '0);

  // Next-state and registered-output logic for the write sequencer
  always_comb begin
    w_state_nx   = r_state;
    w_we_nx      = r_we;
    w_addr_nx    = r_addr;
    w_wdata_nx   = r_wdata;
    w_wrapped_nx = r_wrapped;
    w_pop        = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_wdata_nx = r_fifo[r_rd_ptr];
          w_we_nx    = 1'b1;
          w_state_nx = ST_WRITE;
        end else if (addr_load) begin
          w_addr_nx    = addr_in;
          w_wrapped_nx = 1'b0;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          w_pop = 1'b1;
          w_inc = 1'b1;
`ifdef NOP_PAD_EN
          w_wdata_nx = 32'h0000_0000;
          w_state_nx = ST_PAD;
`else
          w_we_nx    = 1'b0;
          w_state_nx = ST_IDLE;
`endif
        end
      end
`ifdef NOP_PAD_EN
      ST_PAD: begin
        if (mem_ack) begin
          w_inc      = 1'b1;
          w_we_nx    = 1'b0;
          w_state_nx = ST_IDLE;
        end
      end
`endif
      default: begin
        w_we_nx    = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
    if (w_inc) begin
      w_addr_nx = r_addr + ADDR_W'(1);
      if (r_addr == MAX_ADDR) w_wrapped_nx = 1'b1;
    end
  end

  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= RST_ADDR;
      r_wdata   <= '0;
      r_wrapped <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_we      <= w_we_nx;
      r_addr    <= w_addr_nx;
      r_wdata   <= w_wdata_nx;
      r_wrapped <= w_wrapped_nx;
      r_err     <= w_accept & w_illegal;
      r_ready   <= (w_count_nx != FULL_CNT);
      r_busy    <= (w_state_nx != ST_IDLE) | (w_count_nx != '0);
    end
  end

  assign req_ready   = r_ready;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = r_busy;
  assign err_illegal = r_err;
  assign wrapped     = r_wrapped;

endmodule

// File: tb/tb_shift_instr_encoder.sv
// Randomized self-checking bench for shift_instr_encoder against a queue-based reference model.
module tb_shift_instr_encoder;

  localparam int DEPTH   = 4;
  localparam int MAXADDR = 1023;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rt = '0, req_rs = '0, req_shamt = '0;
  logic        addr_load = 1'b0;
  logic [9:0]  addr_in = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy, err_illegal, wrapped;

  shift_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rt(req_rt), .req_rs(req_rs), .req_shamt(req_shamt),
    .addr_load(addr_load), .addr_in(addr_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .err_illegal(err_illegal), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  int unsigned exp_addr = 0;
  bit          exp_wrapped = 0;
  bit          exp_err = 0;
  int          gap = 0;
  logic [31:0] last_wdata = '0;
  int unsigned last_addr = 0;
  int          n_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word layout: {000000, rs, rt, rd, shamt, funct}
  function automatic logic [31:0] model_word(int op, int rd, int rt, int rs, int sh);
    int funct_tbl[6] = '{0, 2, 3, 4, 6, 7};
    bit is_var = (op >= 3);
    int w;
    w = (is_var ? rs : 0) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11)
        + (is_var ? 0 : sh) * 64 + funct_tbl[op];
    return 32'(w);
  endfunction

  task automatic step(input bit v, input int op, input int rd, input int rt, input int rs,
                      input int sh, input bit ack, input bit ld, input int unsigned ain);
    bit acc, pop;
    @(negedge clk);
    check("ready", 32'(req_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
    check("busy", 32'(busy), (q.size() != 0) ? 32'd1 : 32'd0);
    check("err_illegal", 32'(err_illegal), 32'(exp_err));
    check("wrapped", 32'(wrapped), 32'(exp_wrapped));
    check("mem_addr", 32'(mem_addr), exp_addr);
    if (mem_we) begin
      if (q.size() == 0) check("we_while_empty", 32'(mem_we), 32'd0);
      else               check("mem_wdata", mem_wdata, q[0]);
    end
    if (q.size() != 0 && !mem_we) gap++; else gap = 0;
    check("latency", (gap > 1) ? 32'd1 : 32'd0, 32'd0);

    req_valid = v; req_op = 3'(op); req_rd = 5'(rd); req_rt = 5'(rt);
    req_rs = 5'(rs); req_shamt = 5'(sh);
    mem_ack = ack; addr_load = ld; addr_in = 10'(ain);

    acc = v && (q.size() < DEPTH);
    pop = mem_we && ack && (q.size() != 0);
    if (pop) begin
      last_wdata = q.pop_front();
      last_addr  = exp_addr;
      if (exp_addr == MAXADDR) begin exp_addr = 0; exp_wrapped = 1; end
      else exp_addr++;
    end else if (ld && q.size() == 0) begin
      exp_addr = ain; exp_wrapped = 0;
    end
    exp_err = acc && (op >= 6);
    if (acc) n_acc++;
    if (acc && op < 6) q.push_back(model_word(op, rd, rt, rs, sh));
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, ack, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    reset_n = 1'b1;

    // SLL rd=8 rt=9 shamt=4 with ack held high
    step(1, 0, 8, 9, 0, 4, 1, 0, 0);
    idle(5, 1);
    check("sll_word", last_wdata, 32'h00094100);
    check("sll_addr", last_addr, 32'd0);

    // SRAV: shamt field forced to zero
    step(1, 5, 3, 2, 5, 7, 1, 0, 0);
    idle(5, 1);
    check("srav_word", last_wdata, 32'h00A21807);

    // Back-to-back SRLs against a stalled memory fill the FIFO
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_acc = 0;
    for (int i = 0; i < 8; i++) step(n_acc < 5, 1, 1, 2, 0, 31, 0, 0, 0);
    check("fifo_full_accepts", 32'(n_acc), 32'd4);
    for (int i = 0; i < 25; i++) step(n_acc < 5, 1, 1, 2, 0, 31, 1, 0, 0);
    check("fifo_all_accepted", 32'(n_acc), 32'd5);
    check("srl_word", last_wdata, 32'h00020FC2);
    check("srl_last_addr", last_addr, 32'd4);

    // Illegal op, then wrap from the top address
    step(1, 6, 1, 1, 1, 1, 1, 0, 0);
    idle(3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, MAXADDR);
    step(1, 0, 8, 9, 0, 4, 1, 0, 0);
    idle(5, 1);
    check("wrap_last_addr", last_addr, 32'd1023);
    check("wrap_flag", 32'(wrapped), 32'd1);
    check("wrap_addr", 32'(mem_addr), 32'd0);

    // Reset in the middle of a write with three entries queued
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, i, i + 1, 0, i, 0, 0, 0);
    idle(2, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wrapped", 32'(wrapped), 32'd0);
    q.delete(); exp_addr = 0; exp_wrapped = 0; exp_err = 0; gap = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int unsigned ain;
      ain = ($urandom_range(0, 1) == 1) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, MAXADDR);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, ain);
    end
    idle(30, 1);
    check("drain_empty", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_instr_encoder.md
Name: shift_instr_encoder

Overview:
Encodes MIPS R-type shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV) from field-level requests into 32-bit instruction words and writes them sequentially into instruction memory.
This is the producer side of the shift decode path: the words it writes are the ones the decoder later reads to select shamt as ALU operand B.
- Requests are buffered in a small FIFO.
- Memory writes use a req/ack handshake on the DMA-side memory port.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
ADDR_W, 10, word-address width of instruction memory
BASE_ADDR, 0, write-address value after reset

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted
req_op  in  3  0=SLL 1=SRL 2=SRA 3=SLLV 4=SRLV 5=SRAV 6,7=illegal
req_rd  in  5  destination register
req_rt  in  5  source register
req_rs  in  5  shift-amount register (variable shifts only)
req_shamt  in  5  shift amount (fixed shifts only)
addr_load  in  1  load write pointer from addr_in
addr_in  in  ADDR_W  new write pointer
mem_we  out  1  memory write request
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  instruction word
mem_ack  in  1  memory accepted write this cycle
busy  out  1  FIFO non-empty or write in flight
err_illegal  out  1  one-cycle pulse on illegal req_op
wrapped  out  1  sticky: pointer wrapped past max address

Behaviour:
- Reset (async, reset_n=0) clears all state immediately:
  - req_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, err_illegal=0, wrapped=0.
  - FIFO emptied and FSM returns to IDLE, including mid-write; a write in flight is abandoned, not retried.
- Accept rule: a request is accepted on a rising edge where req_valid & req_ready.
  - req_ready = !fifo_full, registered-state based, no combinational path from req_valid.
  - No bypass: when the FIFO is full, a same-cycle pop does not enable a push.
- Encoding, computed at push and stored as the full word: {6'b000000, rs, rt, rd, shamt, funct}.
  - funct: SLL=0x00, SRL=0x02, SRA=0x03, SLLV=0x04, SRLV=0x06, SRAV=0x07.
  - Fixed shifts (op 0-2): rs field=0, shamt field=req_shamt.
  - Variable shifts (op 3-5): shamt field=0, rs field=req_rs.
- Illegal op (6,7): the request is accepted (consumed) but not enqueued; err_illegal pulses high for the cycle after acceptance.
- FSM states: IDLE, WRITE.
  - IDLE: if the FIFO is non-empty, load mem_wdata from the FIFO head, assert mem_we, go to WRITE. First mem_we occurs at the earliest one cycle after the accepting edge.
  - WRITE: mem_we, mem_addr and mem_wdata are held stable until a cycle with mem_ack=1. On that edge: pop the FIFO, mem_addr+=1, deassert mem_we, return to IDLE.
  - Minimum 2 cycles per word. mem_ack while in IDLE is ignored.
- Wrap: an increment from 2^ADDR_W-1 goes to 0 and sets wrapped. wrapped clears only on reset or on an accepted addr_load.
- addr_load: honoured only in IDLE with the FIFO empty, where it sets mem_addr=addr_in and clears wrapped. Otherwise it is ignored silently.
- busy = (state!=IDLE) | !fifo_empty.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.

Optional Feature:
NOP_PAD_EN
- Defined: after each acknowledged instruction word, the FSM enters a PAD state and writes 0x00000000 (SLL $0,$0,0) at the next address with the same handshake, then returns to IDLE. The address advances by 2 per request, and wrap rules apply to each increment. busy stays high through PAD.
- Undefined: no PAD state exists and behaviour is exactly as above.

Test Plan:
- SLL rd=8 rt=9 shamt=4, mem_ack held 1 after reset -> one write: mem_addr=0, mem_wdata=0x00094100; mem_addr=1 afterwards, busy=0.
- SRAV rd=3 rt=2 rs=5 shamt=7 -> mem_wdata=0x00A21807 (shamt field forced 0).
- Five back-to-back SRL rd=1 rt=2 shamt=31 with mem_ack=0 -> req_ready drops after 4 accepts. Release ack -> 4 writes of 0x00020FC2 at addrs 0..3, then the 5th is accepted and written at 4.
- req_op=6 -> err_illegal pulses exactly 1 cycle, no mem_we, busy stays 0. addr_load with addr_in=1023, then SLL -> write at 1023, mem_addr=0, wrapped=1.
- Assert reset_n=0 while mem_we=1 and the FIFO holds 3 entries -> mem_we=0 immediately, FIFO empty, mem_addr=BASE_ADDR. With NOP_PAD_EN: a single SLL produces words at addrs 0 and 1, the second being 0x00000000.
